// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480@60 timing defaults, derived totals and pixel type
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL = axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL = axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  typedef struct packed {
    logic [3:0] blue;
    logic [3:0] green;
    logic [3:0] red;
  } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping axis counter with visible and sync-window decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             visible,
  output logic             sync
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(VISIBLE + FRONT + SYNC - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign wrap    = en && (count == LAST);
  assign visible = count < VIS_END;
  assign sync    = (count >= SYNC_FIRST) && (count <= SYNC_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with registered sync and RGB outputs
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic [11:0] pixel_color,
  output logic [9:0]  X_pix,
  output logic [9:0]  Y_pix,
  output logic        H_visible,
  output logic        V_visible,
  output logic        pixel_clk,
  output logic [9:0]  pixel_cnt,
  output logic        frame_start,
  output logic [3:0]  VGA_BUS_R,
  output logic [3:0]  VGA_BUS_G,
  output logic [3:0]  VGA_BUS_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam logic [9:0] PCNT_MAX = 10'(H_VISIBLE);

  logic h_wrap;
  logic v_wrap;
  logic h_sync;
  logic v_sync;
  logic at_origin;
  rgb_t color;

  assign color = rgb_t'(pixel_color);

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      pixel_clk <= 1'b0;
    end else begin
      pixel_clk <= ~pixel_clk;
    end
  end

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_counter (
    .clk(clk_50), .rst(rst), .en(pixel_clk),
    .count(X_pix), .wrap(h_wrap), .visible(H_visible), .sync(h_sync)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_counter (
    .clk(clk_50), .rst(rst), .en(h_wrap),
    .count(Y_pix), .wrap(v_wrap), .visible(V_visible), .sync(v_sync)
  );

  // at_origin tracks "counters sit at (0,0)" so frame_start needs no wide compare
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BUS_R <= '0;
      VGA_BUS_G <= '0;
      VGA_BUS_B <= '0;
      pixel_cnt <= '0;
      at_origin <= 1'b1;
    end else if (pixel_clk) begin
      VGA_HS    <= ~h_sync;
      VGA_VS    <= ~v_sync;
      at_origin <= v_wrap;
      if (H_visible && V_visible) begin
        VGA_BUS_R <= color.red;
        VGA_BUS_G <= color.green;
        VGA_BUS_B <= color.blue;
      end else begin
        VGA_BUS_R <= '0;
        VGA_BUS_G <= '0;
        VGA_BUS_B <= '0;
      end
      if (h_wrap) begin
        pixel_cnt <= '0;
      end else if (H_visible && V_visible && (pixel_cnt < PCNT_MAX)) begin
        pixel_cnt <= pixel_cnt + 1'b1;
      end
    end
  end

  assign frame_start = pixel_clk && at_origin;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

  localparam int HV = 20, HF = 4, HS = 6, HB = 5;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct {
    int          x;
    int          y;
    bit          hvis;
    bit          vvis;
    bit          pclk;
    bit          fs;
    bit          hs;
    bit          vs;
    int          pcnt;
    logic [11:0] rgb;
  } exp_t;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic [11:0] pixel_color;
  logic [9:0]  X_pix, Y_pix, pixel_cnt;
  logic        H_visible, V_visible, pixel_clk, frame_start;
  logic [3:0]  VGA_BUS_R, VGA_BUS_G, VGA_BUS_B;
  logic        VGA_HS, VGA_VS;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          n = 0;
  logic [11:0] cur_col = '0;
  logic [11:0] last_col = '0;
  int          mcyc = 0;
  int          fs_last = -1;
  int          periods = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk_50(clk_50), .rst(rst), .pixel_color(pixel_color),
    .X_pix(X_pix), .Y_pix(Y_pix), .H_visible(H_visible), .V_visible(V_visible),
    .pixel_clk(pixel_clk), .pixel_cnt(pixel_cnt), .frame_start(frame_start),
    .VGA_BUS_R(VGA_BUS_R), .VGA_BUS_G(VGA_BUS_G), .VGA_BUS_B(VGA_BUS_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
  );

  always #5 clk_50 = ~clk_50;

  // n = clk_50 edges since reset release; raster position follows from n/2 pixel ticks
  function automatic exp_t model(input int edges, input logic [11:0] col);
    exp_t e;
    int t, p, pp, xp, yp;
    t      = edges / 2;
    p      = t % FT;
    e.x    = p % HT;
    e.y    = p / HT;
    e.hvis = e.x < HV;
    e.vvis = e.y < VV;
    e.pclk = (edges % 2) == 1;
    e.pcnt = (e.y < VV) ? ((e.x < HV) ? e.x : HV) : 0;
    e.fs   = e.pclk && (p == 0);
    if (t == 0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.rgb = '0;
    end else begin
      pp    = (t - 1) % FT;
      xp    = pp % HT;
      yp    = pp / HT;
      e.hs  = !(xp >= HV + HF && xp < HV + HF + HS);
      e.vs  = !(yp >= VV + VF && yp < VV + VF + VS);
      e.rgb = (xp < HV && yp < VV) ? col : 12'h000;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, mcyc);
    end
  endtask

  // mode 0: plain cycle, 1: assert rst mid-cycle, 2: release rst just after the edge
  task automatic step(input int mode, input bit white);
    @(posedge clk_50);
    if (!rst) begin
      n++;
      if (n % 2 == 0) last_col = cur_col;
    end
    #1;
    if (mode == 2) rst = 1'b0;
    if (mode == 1) begin
      #1;
      rst = 1'b1;
      n   = 0;
    end
    q.push_back(model(n, last_col));
    cur_col     = white ? 12'hFFF : 12'($urandom);
    pixel_color = cur_col;
  endtask

  always @(negedge clk_50) begin
    exp_t e;
    mcyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("x_pix", X_pix, e.x);
      chk("y_pix", Y_pix, e.y);
      chk("h_visible", H_visible, int'(e.hvis));
      chk("v_visible", V_visible, int'(e.vvis));
      chk("pixel_clk", pixel_clk, int'(e.pclk));
      chk("pixel_cnt", pixel_cnt, e.pcnt);
      chk("frame_start", frame_start, int'(e.fs));
      chk("vga_hs", VGA_HS, int'(e.hs));
      chk("vga_vs", VGA_VS, int'(e.vs));
      chk("rgb", {VGA_BUS_B, VGA_BUS_G, VGA_BUS_R}, int'(e.rgb));
    end
    if (rst) begin
      fs_last = -1;
    end else if (frame_start === 1'b1) begin
      if (fs_last >= 0) begin
        chk("frame_period", mcyc - fs_last, 2 * FT);
        periods++;
      end
      fs_last = mcyc;
    end
  end

  initial begin
    int guard;
    exp_t pos;
    rst         = 1'b1;
    pixel_color = '0;
    repeat (3) step(0, 1'b0);
    step(2, 1'b0);
    repeat (1500) step(0, 1'b0);

    guard = 0;
    pos   = model(n, last_col);
    while (!(pos.x == 15 && pos.y == 7) && guard < 3000) begin
      step(0, 1'b0);
      pos = model(n, last_col);
      guard++;
    end
    if (guard >= 3000) begin
      total++;
      bad++;
      $display("FAIL reach_midframe: got guard %0d want position (15,7)", guard);
    end

    step(1, 1'b0);
    repeat (2) step(0, 1'b0);
    step(2, 1'b1);
    repeat (2800) step(0, 1'b1);

    guard = 0;
    while (q.size() != 0 && guard < 5) begin
      @(negedge clk_50);
      guard++;
    end
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    chk("frame_periods_seen", (periods >= 3) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
